// File: rtl/f_fetch_unit_pkg.sv
// Shared definitions for the F-stage fetch unit: FSM encoding, reset PC,
// NOP word and the IF/ID payload layout.
package f_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    localparam int IFID_W = $bits(ifid_t);

    function automatic ifid_t ifid_reset_value();
        ifid_t v;
        v.pc    = 32'h0000_0000;
        v.instr = NOP_INSTR;
        return v;
    endfunction

endpackage

// File: rtl/f_fetch_unit_ifid_reg.sv
// Generic enabled pipeline register with synchronous active-high reset,
// used for IF/ID and reusable for the later stage boundaries.
module ifid_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/f_fetch_unit.sv
// F-stage front end: PC register, instruction-memory req/gnt/rvalid fetch
// FSM with a one-word response buffer, and the IF/ID pipeline register.
module f_fetch_unit
    import f_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        d_stall,
    output logic [31:0] f_pc,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        f_busy,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata
);

    fetch_state_e state, next_state;
    logic [31:0]  pc_q;
    logic [31:0]  buf_instr;
    logic [31:0]  fetched_instr;
    logic         avail;
    logic         adv;
    logic         capture;
    ifid_t        ifid_d;
    ifid_t        ifid_q;

    always_comb begin
        avail         = ((state == S_WAIT) && im_rvalid) || (state == S_HOLD);
        adv           = avail && !d_stall;
        capture       = (state == S_WAIT) && im_rvalid && d_stall;
        fetched_instr = (state == S_HOLD) ? buf_instr : im_rdata;
        ifid_d.pc     = pc_q;
        ifid_d.instr  = fetched_instr;
    end

    // An advance both retires the current fetch and issues the next one,
    // bypassing npc onto the bus so a zero-wait memory sustains 1 instr/cycle.
    always_comb begin
        next_state = state;
        im_req     = 1'b0;
        im_addr    = pc_q;
        unique case (state)
            S_REQ: begin
                im_req = 1'b1;
                if (im_gnt) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (capture) begin
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                next_state = S_HOLD;
            end
            default: begin
                next_state = S_REQ;
            end
        endcase
        if (adv) begin
            im_req     = 1'b1;
            im_addr    = npc;
            next_state = im_gnt ? S_WAIT : S_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_REQ;
            pc_q      <= RESET_PC;
            buf_instr <= 32'h0000_0000;
        end else begin
            state <= next_state;
            if (adv) begin
                pc_q <= npc;
            end
            if (capture) begin
                buf_instr <= im_rdata;
            end
        end
    end

    ifid_reg #(
        .WIDTH     (IFID_W),
        .RESET_VAL (ifid_reset_value())
    ) u_ifid (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    always_comb begin
        f_pc       = pc_q;
        ifid_pc    = ifid_q.pc;
        ifid_instr = ifid_q.instr;
        f_busy     = !avail;
    end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed bench for f_fetch_unit: a small memory model returns mem[a] = a
// with tunable grant blocking and response latency; expectations are hand-computed.
module tb_f_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] npc;
    logic        d_stall = 1'b0;
    logic [31:0] f_pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        f_busy;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;

    int          total = 0;
    int          bad = 0;

    // Memory and next-PC model knobs.
    int          rv_extra = 0;
    logic        gnt_block = 1'b0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_pc = 32'h0;
    logic [31:0] branch_tgt = 32'h0;
    logic        pending = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    int          gnt_cnt = 0;
    int          g0;

    f_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .d_stall    (d_stall),
        .f_pc       (f_pc),
        .ifid_pc    (ifid_pc),
        .ifid_instr (ifid_instr),
        .f_busy     (f_busy),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_gnt     (im_gnt),
        .im_rvalid  (im_rvalid),
        .im_rdata   (im_rdata)
    );

    always #5 clk = ~clk;

    // Grant is combinational on req; rv_extra counts cycles beyond the
    // zero-wait response, so each one should cost one f_busy cycle.
    always_comb begin
        im_gnt    = im_req && !gnt_block;
        im_rvalid = pending && (pend_cnt == 0);
        im_rdata  = im_rvalid ? pend_addr : 32'hDEAD_BEEF;
        npc       = (branch_en && (ifid_pc == branch_pc)) ? branch_tgt : f_pc + 32'd4;
    end

    always @(posedge clk) begin
        if (reset) begin
            pending  <= 1'b0;
            pend_cnt <= 0;
        end else if (im_gnt) begin
            pending   <= 1'b1;
            pend_addr <= im_addr;
            pend_cnt  <= rv_extra;
        end else if (im_rvalid) begin
            pending <= 1'b0;
        end else if (pending) begin
            pend_cnt <= pend_cnt - 1;
        end
        if (im_gnt && !reset) begin
            gnt_cnt <= gnt_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic busy, input logic req,
                              input logic [31:0] addr, input logic [31:0] fpc,
                              input logic [31:0] ipc, input logic [31:0] iinstr);
        checkOutput({tag, ".f_busy"}, {31'b0, f_busy}, {31'b0, busy});
        checkOutput({tag, ".im_req"}, {31'b0, im_req}, {31'b0, req});
        if (req) begin
            checkOutput({tag, ".im_addr"}, im_addr, addr);
        end
        checkOutput({tag, ".f_pc"}, f_pc, fpc);
        checkOutput({tag, ".ifid_pc"}, ifid_pc, ipc);
        checkOutput({tag, ".ifid_instr"}, ifid_instr, iinstr);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic stall, input logic block);
        d_stall   = stall;
        gnt_block = block;
        #1;
    endtask

    task automatic doReset(input int extra);
        reset     = 1'b1;
        d_stall   = 1'b0;
        gnt_block = 1'b0;
        branch_en = 1'b0;
        rv_extra  = extra;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Reset asserted mid-cycle, held across exactly one posedge.
    task automatic pulseReset();
        reset   = 1'b1;
        d_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        $display("[TB] start");

        // Zero-wait stream from reset.
        doReset(0);
        checkState("rst", 1'b1, 1'b1, 32'h3000, 32'h3000, 32'h0, 32'h0);
        stepCycle();
        checkState("zw1", 1'b0, 1'b1, 32'h3004, 32'h3000, 32'h0, 32'h0);
        for (int k = 2; k <= 5; k++) begin
            stepCycle();
            checkState($sformatf("zw%0d", k), 1'b0, 1'b1, 32'h3000 + 32'(4 * k),
                       32'h3000 + 32'(4 * (k - 1)), 32'h3000 + 32'(4 * (k - 2)),
                       32'h3000 + 32'(4 * (k - 2)));
        end

        // Branch at 0x3004 to 0x3100: delay slot 0x3008 still executes.
        doReset(0);
        branch_en  = 1'b1;
        branch_pc  = 32'h3004;
        branch_tgt = 32'h3100;
        stepCycle();
        stepCycle();
        checkState("br2", 1'b0, 1'b1, 32'h3008, 32'h3004, 32'h3000, 32'h3000);
        stepCycle();
        checkState("br3", 1'b0, 1'b1, 32'h3100, 32'h3008, 32'h3004, 32'h3004);
        stepCycle();
        checkState("br4", 1'b0, 1'b1, 32'h3104, 32'h3100, 32'h3008, 32'h3008);
        stepCycle();
        checkState("br5", 1'b0, 1'b1, 32'h3108, 32'h3104, 32'h3100, 32'h3100);
        branch_en = 1'b0;

        // Three extra cycles of response latency.
        doReset(3);
        stepCycle();
        checkState("lat1", 1'b1, 1'b0, 32'h0, 32'h3000, 32'h0, 32'h0);
        stepCycle();
        stepCycle();
        stepCycle();
        checkState("lat4", 1'b0, 1'b1, 32'h3004, 32'h3000, 32'h0, 32'h0);
        for (int k = 5; k <= 7; k++) begin
            stepCycle();
            checkState($sformatf("lat%0d", k), 1'b1, 1'b0, 32'h0, 32'h3004, 32'h3000, 32'h3000);
        end
        stepCycle();
        checkState("lat8", 1'b0, 1'b1, 32'h3008, 32'h3004, 32'h3000, 32'h3000);
        stepCycle();
        checkState("lat9", 1'b1, 1'b0, 32'h0, 32'h3008, 32'h3004, 32'h3004);

        // Response for 0x300C arrives while D is stalled for 4 cycles.
        doReset(0);
        repeat (4) stepCycle();
        applyStimulus(1'b1, 1'b0);
        checkState("stl4", 1'b0, 1'b0, 32'h0, 32'h300C, 32'h3008, 32'h3008);
        for (int k = 5; k <= 7; k++) begin
            stepCycle();
            checkState($sformatf("stl%0d", k), 1'b0, 1'b0, 32'h0, 32'h300C, 32'h3008, 32'h3008);
        end
        stepCycle();
        applyStimulus(1'b0, 1'b0);
        checkState("stl8", 1'b0, 1'b1, 32'h3010, 32'h300C, 32'h3008, 32'h3008);
        stepCycle();
        checkState("stl9", 1'b0, 1'b1, 32'h3014, 32'h3010, 32'h300C, 32'h300C);

        // Grant withheld for 5 cycles on the 0x3010 request.
        doReset(0);
        repeat (4) stepCycle();
        applyStimulus(1'b0, 1'b1);
        g0 = gnt_cnt;
        checkState("gnt4", 1'b0, 1'b1, 32'h3010, 32'h300C, 32'h3008, 32'h3008);
        for (int k = 5; k <= 8; k++) begin
            stepCycle();
            checkState($sformatf("gnt%0d", k), 1'b1, 1'b1, 32'h3010, 32'h3010, 32'h300C, 32'h300C);
        end
        stepCycle();
        applyStimulus(1'b0, 1'b0);
        checkState("gnt9", 1'b1, 1'b1, 32'h3010, 32'h3010, 32'h300C, 32'h300C);
        stepCycle();
        checkState("gnt10", 1'b0, 1'b1, 32'h3014, 32'h3010, 32'h300C, 32'h300C);
        checkOutput("gnt_once", 32'(gnt_cnt - g0), 32'd1);
        stepCycle();
        checkState("gnt11", 1'b0, 1'b1, 32'h3018, 32'h3014, 32'h3010, 32'h3010);

        // Reset in S_WAIT while a response is being accepted.
        doReset(0);
        repeat (3) stepCycle();
        pulseReset();
        checkState("rw0", 1'b1, 1'b1, 32'h3000, 32'h3000, 32'h0, 32'h0);
        stepCycle();
        checkState("rw1", 1'b0, 1'b1, 32'h3004, 32'h3000, 32'h0, 32'h0);
        stepCycle();
        checkState("rw2", 1'b0, 1'b1, 32'h3008, 32'h3004, 32'h3000, 32'h3000);

        // Reset in S_HOLD with a buffered word and stall dropping together.
        doReset(0);
        repeat (2) stepCycle();
        applyStimulus(1'b1, 1'b0);
        stepCycle();
        checkState("rh3", 1'b0, 1'b0, 32'h0, 32'h3004, 32'h3000, 32'h3000);
        pulseReset();
        checkState("rh0", 1'b1, 1'b1, 32'h3000, 32'h3000, 32'h0, 32'h0);
        stepCycle();
        checkState("rh1", 1'b0, 1'b1, 32'h3004, 32'h3000, 32'h0, 32'h0);
        stepCycle();
        checkState("rh2", 1'b0, 1'b1, 32'h3008, 32'h3004, 32'h3000, 32'h3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/f_fetch_unit.md
# f_fetch_unit

F-stage front end of the five-stage pipeline: owns the PC register, issues instruction-memory fetches over a req/gnt/rvalid handshake, and owns the IF/ID pipeline register. It consumes the next-PC value from the D-stage next-PC logic and drives that logic's two PC inputs, the F-stage PC and the IF/ID PC. It absorbs variable instruction-memory latency and tells the hazard logic when no instruction is available.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction word held in IF/ID after reset.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- npc  in  32  next PC from D-stage next-PC logic; valid whenever an advance occurs.
- d_stall  in  1  hazard-unit stall request for D, excluding f_busy.
- f_pc  out  32  current F-stage PC (pc_q).
- ifid_pc  out  32  PC of the instruction in D.
- ifid_instr  out  32  instruction in D.
- f_busy  out  1  high when F cannot supply an instruction this cycle. Global stall = d_stall | f_busy.
- im_req  out  1  fetch request.
- im_addr  out  32  fetch word address.
- im_gnt  in  1  request accepted this cycle.
- im_rvalid  in  1  response data valid; at most one outstanding request.
- im_rdata  in  32  fetched instruction.

## Operation
- State registers:
  - FSM: S_REQ, S_WAIT, S_HOLD.
  - pc_q, buf_instr, ifid_pc, ifid_instr.
- avail = (S_WAIT & im_rvalid) | S_HOLD; f_busy = ~avail.
- adv = avail & ~d_stall. Only an advance updates pc_q and IF/ID.
- On adv:
  - ifid_pc <= pc_q.
  - ifid_instr <= im_rdata in S_WAIT, or buf_instr in S_HOLD.
  - pc_q <= npc.
  - Same cycle: im_req=1, im_addr=npc (bypass).
  - Next state: S_WAIT if im_gnt, else S_REQ.
- S_REQ: im_req=1, im_addr=pc_q. Go to S_WAIT on im_gnt; otherwise hold.
- S_WAIT:
  - No rvalid: im_req=0, hold.
  - rvalid with d_stall: buf_instr <= im_rdata, go to S_HOLD.
  - rvalid without d_stall: advance as above.
- S_HOLD: im_req=0. Advance when d_stall drops.
- Without an advance, pc_q, ifid_pc and ifid_instr hold. This keeps npc (a function of f_pc and IF/ID) stable while stalled, so branch and jump targets are never lost.
- No IF/ID flush: the branch delay slot is always executed.
- pc_q + 4 is computed by the next-PC logic, not here. Wrap at 2^32 is natural modulo arithmetic.

## Timing
- Reset values:
  - pc_q = RESET_PC, state = S_REQ, ifid_pc = 0, ifid_instr = NOP_INSTR, buf_instr = 0.
  - Outputs in the cycle after reset: f_busy=1, im_req=1, im_addr=RESET_PC.
- Instruction memory resets on the same reset. A request outstanding at reset is abandoned and never answered.
- Reset dominates every event, including rvalid and gnt in the same cycle.
- Zero-wait memory (gnt with req, rvalid the next cycle): first instruction reaches IF/ID at the end of cycle 2 after reset release. Throughput is then 1 instruction/cycle.
- Each extra cycle of gnt or rvalid latency adds one f_busy cycle.
- rvalid and d_stall together: data buffered, no advance, no new request.
- d_stall while in S_REQ or S_WAIT is irrelevant; f_busy already freezes D.
- im_req, once raised, stays high with a stable im_addr until gnt. The exception is the advance cycle, where im_addr switches to npc.

## Structure
- Shared package:
  - FSM state encoding (2 bits).
  - RESET_PC default 32'h0000_3000.
  - NOP encoding.
- Single module. A separate pipeline-register sub-module, ifid_reg (en, d, q), holding {pc, instr} is natural and reusable for later stages.

## Test plan
- Reset, zero-wait memory returning mem[a] = a: im_addr sequence 0x3000, 0x3004, 0x3008 on consecutive cycles. ifid_pc follows one cycle behind the response. f_busy low from cycle 2.
- npc = 0x3100 driven when ifid holds a branch at 0x3004: delay slot 0x3008 enters IF/ID, then 0x3100 is fetched; no instruction is skipped or duplicated.
- Three-cycle rvalid latency: f_busy high 3 cycles per fetch. ifid_pc and f_pc are stable throughout.
- rvalid at 0x300C coincident with d_stall=1 for 4 cycles: no im_req; ifid unchanged. On release, ifid_instr = buffered word and im_addr = npc in the same cycle.
- gnt withheld 5 cycles: im_req and im_addr=0x3010 stable the whole time; single gnt leads to a single rvalid.
- reset asserted in S_WAIT and in S_HOLD: next cycle f_pc=0x3000, ifid_instr=NOP, im_req=1; no stale data enters IF/ID.
